// File: rtl/fir_mac_sequencer_pkg.sv
// Shared definitions for the serial-tap FIR engine: multiplier width,
// default tap count and the sequencer state encoding.
package fir_mac_sequencer_pkg;

    // Width of the shared signed multiplier operands and returned product MSBs.
    localparam int BF_MULT_BITS = 16;

    // Default number of filter taps.
    localparam int FIR_TAPS = 8;

    // Sequencer states: wait for a sample, step taps through the multiplier,
    // hold the result for the consumer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } firState_t;

endpackage

// File: rtl/fir_sat_trunc.sv
// Combinational saturating narrower: clips a signed IN_BITS value into the
// signed OUT_BITS range. Intended for reuse by later filter stages.
module fir_sat_trunc #(
    parameter int IN_BITS  = 19,
    parameter int OUT_BITS = 16
) (
    input  logic [IN_BITS-1:0]  inVal,
    output logic [OUT_BITS-1:0] outVal
);

    // The value fits when every bit from the output sign bit upward agrees.
    logic [IN_BITS-OUT_BITS:0] topBits;
    assign topBits = inVal[IN_BITS-1:OUT_BITS-1];

    // Pass through when in range, otherwise clamp toward the input's sign.
    always_comb begin
        outVal = inVal[OUT_BITS-1:0];
        if (!(&topBits) && (|topBits)) begin
            if (inVal[IN_BITS-1]) begin
                outVal = {1'b1, {(OUT_BITS-1){1'b0}}};
            end else begin
                outVal = {1'b0, {(OUT_BITS-1){1'b1}}};
            end
        end
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// Serial-tap FIR engine. Each accepted sample shifts the delay line, then one
// tap per clock is presented to an external signed multiplier; the returned
// product MSBs are accumulated and the saturated sum is offered downstream.
module fir_mac_sequencer
    import fir_mac_sequencer_pkg::*;
#(
    parameter int BITS     = BF_MULT_BITS,
    parameter int TAPS     = FIR_TAPS,
    parameter int ACC_BITS = BITS + $clog2(TAPS)
) (
    input  logic                     xClk,
    input  logic                     xRst_n,
    input  logic [BITS-1:0]          xInData,
    input  logic                     xInValid,
    output logic                     xInReady,
    input  logic                     xCoefWe,
    input  logic [$clog2(TAPS)-1:0]  xCoefAddr,
    input  logic [BITS-1:0]          xCoefData,
    output logic [BITS-1:0]          xMulA,
    output logic [BITS-1:0]          xMulB,
    input  logic [BITS-1:0]          xMulP,
    output logic [BITS-1:0]          xOutData,
    output logic                     xOutValid,
    input  logic                     xOutReady,
    output logic                     xBusy
);

    localparam int AW = $clog2(TAPS);
    // One extra bit so the counter can reach TAPS (the finishing cycle).
    localparam int KW = AW + 1;

    firState_t         stateReg;
    firState_t         stateNext;

    logic [BITS-1:0]     tapReg  [TAPS];
    logic [BITS-1:0]     coefReg [TAPS];
    logic [ACC_BITS-1:0] accReg;
    logic [KW-1:0]       kReg;

    logic                sampleAccept;
    logic                coefWriteOk;
    logic                macFinish;
    logic                macLastLoad;
    logic [AW-1:0]       kIdxNext;
    logic [BITS-1:0]     coef0Fwd;
    logic [ACC_BITS-1:0] prodExt;
    logic [BITS-1:0]     satVal;

    assign sampleAccept = (stateReg == IDLE) && xInValid;
    // Coefficients only change while no result is being computed.
    assign coefWriteOk  = (stateReg == IDLE) && xCoefWe;
    // All TAPS products have been added once the counter reaches TAPS.
    assign macFinish    = (kReg == KW'(TAPS));
    // Operands for tap k+1 are only loaded while another tap remains.
    assign macLastLoad  = (kReg >= KW'(TAPS - 1));
    assign kIdxNext     = kReg[AW-1:0] + AW'(1);
    // A coefficient write coinciding with the accepted sample lands first.
    assign coef0Fwd     = (coefWriteOk && (xCoefAddr == AW'(0))) ? xCoefData : coefReg[0];
    assign prodExt      = {{(ACC_BITS-BITS){xMulP[BITS-1]}}, xMulP};

    assign xInReady  = (stateReg == IDLE);
    assign xOutValid = (stateReg == DONE);
    assign xBusy     = (stateReg == MAC) || (stateReg == DONE);

    fir_sat_trunc #(
        .IN_BITS  (ACC_BITS),
        .OUT_BITS (BITS)
    ) uSat (
        .inVal  (accReg),
        .outVal (satVal)
    );

    // State register.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state: accept a sample, run the taps, wait for the consumer.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (sampleAccept) stateNext = MAC;
            MAC:     if (macFinish)    stateNext = DONE;
            DONE:    if (xOutReady)    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Sample delay line: newest sample enters tap 0, the oldest falls off.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                tapReg[i] <= '0;
            end
        end else if (sampleAccept) begin
            tapReg[0] <= xInData;
            for (int i = 1; i < TAPS; i++) begin
                tapReg[i] <= tapReg[i-1];
            end
        end
    end

    // Coefficient bank, writable only in IDLE; other writes are dropped.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                coefReg[i] <= '0;
            end
        end else if (coefWriteOk) begin
            coefReg[xCoefAddr] <= xCoefData;
        end
    end

    // Multiply-accumulate datapath: load operands, add product MSBs, and
    // capture the saturated sum as the sequence completes.
    always_ff @(posedge xClk or negedge xRst_n) begin
        if (!xRst_n) begin
            accReg   <= '0;
            kReg     <= '0;
            xMulA    <= '0;
            xMulB    <= '0;
            xOutData <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (sampleAccept) begin
                        accReg <= '0;
                        kReg   <= '0;
                        // The new sample is tap 0 of this result.
                        xMulA  <= xInData;
                        xMulB  <= coef0Fwd;
                    end
                end
                MAC: begin
                    if (macFinish) begin
                        xOutData <= satVal;
                    end else begin
                        accReg <= accReg + prodExt;
                        kReg   <= kReg + KW'(1);
                        if (!macLastLoad) begin
                            xMulA <= tapReg[kIdxNext];
                            xMulB <= coefReg[kIdxNext];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Self-checking bench for fir_mac_sequencer: table-driven filter vectors,
// hand-written sequences for coefficient gating and mid-run reset, then
// randomized samples and coefficients checked against a behavioural model.
module tb_fir_mac_sequencer;

    localparam int BITS = 16;
    localparam int TAPS = 8;

    logic            xClk = 1'b0;
    logic            xRst_n = 1'b0;
    logic [BITS-1:0] xInData = '0;
    logic            xInValid = 1'b0;
    logic            xInReady;
    logic            xCoefWe = 1'b0;
    logic [2:0]      xCoefAddr = '0;
    logic [BITS-1:0] xCoefData = '0;
    logic [BITS-1:0] xMulA;
    logic [BITS-1:0] xMulB;
    logic [BITS-1:0] xMulP;
    logic [BITS-1:0] xOutData;
    logic            xOutValid;
    logic            xOutReady = 1'b0;
    logic            xBusy;

    always #5 xClk = ~xClk;

    // Shared signed multiplier returning the product MSBs.
    logic signed [2*BITS-1:0] mulFull;
    assign mulFull = $signed(xMulA) * $signed(xMulB);
    assign xMulP   = mulFull[2*BITS-1:BITS];

    fir_mac_sequencer #(.BITS(BITS), .TAPS(TAPS)) dut (
        .xClk      (xClk),
        .xRst_n    (xRst_n),
        .xInData   (xInData),
        .xInValid  (xInValid),
        .xInReady  (xInReady),
        .xCoefWe   (xCoefWe),
        .xCoefAddr (xCoefAddr),
        .xCoefData (xCoefData),
        .xMulA     (xMulA),
        .xMulB     (xMulB),
        .xMulP     (xMulP),
        .xOutData  (xOutData),
        .xOutValid (xOutValid),
        .xOutReady (xOutReady),
        .xBusy     (xBusy)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model: coefficient values and sample history, newest first.
    int mdlCoef [TAPS];
    int mdlHist [TAPS];

    typedef struct {
        bit          load;
        logic [15:0] coef;
        logic [15:0] sample;
        logic [15:0] expected;
        bit          chk;
        int          hold;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge xClk);
        #1;
    endtask

    function automatic logic [15:0] modelY();
        longint sum = 0;
        for (int k = 0; k < TAPS; k++) begin
            longint p = longint'(mdlCoef[k]) * longint'(mdlHist[k]);
            sum += (p >>> 16);
        end
        if (sum > 32767) return 16'h7FFF;
        if (sum < -32768) return 16'h8000;
        return 16'(sum);
    endfunction

    task automatic modelClear();
        for (int k = 0; k < TAPS; k++) begin
            mdlCoef[k] = 0;
            mdlHist[k] = 0;
        end
    endtask

    task automatic writeCoef(input int addr, input logic [15:0] val);
        xCoefWe   = 1'b1;
        xCoefAddr = 3'(addr);
        xCoefData = val;
        tick();
        xCoefWe = 1'b0;
        mdlCoef[addr] = int'($signed(val));
    endtask

    task automatic loadAll(input logic [15:0] val);
        for (int k = 0; k < TAPS; k++) writeCoef(k, val);
    endtask

    // One full transaction: offer a sample, wait for the result, hold the
    // consumer off for 'hold' cycles, then accept.
    task automatic pushSample(input logic [15:0] s, input int hold, input bit midWrite,
                              input bit simWrite, input logic [15:0] expTab,
                              input bit chkTab, input string tag);
        int          waitN = 0;
        int          edges = 0;
        bit          busyOk = 1'b1;
        bit          stableOk = 1'b1;
        logic [15:0] expM;
        logic [15:0] got;
        while (!xInReady && waitN < 50) begin
            tick();
            waitN++;
        end
        check({tag, "_ready"}, 32'(xInReady), 32'd1);
        xInValid = 1'b1;
        xInData  = s;
        if (simWrite) begin
            xCoefWe   = 1'b1;
            xCoefAddr = 3'd0;
            xCoefData = 16'h1000;
            mdlCoef[0] = 32'h1000;
        end
        tick();
        xInValid = 1'b0;
        xCoefWe  = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) mdlHist[k] = mdlHist[k-1];
        mdlHist[0] = int'($signed(s));
        expM = modelY();
        while (!xOutValid && edges < 30) begin
            if (midWrite && edges == 2) begin
                xCoefWe   = 1'b1;
                xCoefAddr = 3'd0;
                xCoefData = 16'h1000;
            end
            tick();
            xCoefWe = 1'b0;
            edges++;
            if (!xOutValid && (xInReady || !xBusy)) busyOk = 1'b0;
        end
        check({tag, "_latency"}, 32'(edges), 32'(TAPS + 1));
        check({tag, "_busy"}, 32'(busyOk), 32'd1);
        check({tag, "_model"}, 32'(xOutData), 32'(expM));
        if (chkTab) check({tag, "_table"}, 32'(xOutData), 32'(expTab));
        got = xOutData;
        for (int h = 0; h < hold; h++) begin
            tick();
            if (xOutData !== got || !xOutValid || xInReady || !xBusy) stableOk = 1'b0;
        end
        if (hold > 0) check({tag, "_hold"}, 32'(stableOk), 32'd1);
        xOutReady = 1'b1;
        tick();
        xOutReady = 1'b0;
        check({tag, "_release"}, {30'd0, xOutValid, xInReady}, 32'b01);
    endtask

    task automatic addVec(input bit load, input logic [15:0] coef, input logic [15:0] sample,
                          input logic [15:0] expected, input bit chk, input int hold);
        vec_t v;
        v.load = load; v.coef = coef; v.sample = sample;
        v.expected = expected; v.chk = chk; v.hold = hold;
        vecs.push_back(v);
    endtask

    // Watchdog so the bench always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          sawValid;
        logic [15:0] rs;
        modelClear();

        // Reset state.
        #2;
        check("rst_inReady", 32'(xInReady), 32'd1);
        check("rst_outValid", 32'(xOutValid), 32'd0);
        check("rst_outData", 32'(xOutData), 32'd0);
        check("rst_mulAB", {xMulA, xMulB}, 32'd0);
        check("rst_busy", 32'(xBusy), 32'd0);
        tick();
        xRst_n = 1'b1;
        tick();

        // Impulse: all coef 0x4000, 0x7FFF then zeros.
        addVec(1'b1, 16'h4000, 16'h7FFF, 16'h1FFF, 1'b1, 0);
        for (int i = 1; i < 8; i++) addVec(1'b0, 16'h0, 16'h0000, 16'h1FFF, 1'b1, (i == 3) ? 5 : 0);
        addVec(1'b0, 16'h0, 16'h0000, 16'h0000, 1'b1, 0);
        // Positive saturation.
        addVec(1'b1, 16'h7FFF, 16'h7FFF, 16'h3FFF, 1'b1, 0);
        addVec(1'b0, 16'h0, 16'h7FFF, 16'h7FFE, 1'b1, 0);
        for (int i = 2; i < 8; i++) addVec(1'b0, 16'h0, 16'h7FFF, 16'h7FFF, 1'b1, 0);
        // Flush back to an empty history.
        for (int i = 0; i < 7; i++) addVec(1'b0, 16'h0, 16'h0000, 16'h0, 1'b0, 0);
        addVec(1'b0, 16'h0, 16'h0000, 16'h0000, 1'b1, 0);
        // Negative saturation.
        addVec(1'b0, 16'h0, 16'h8000, 16'hC000, 1'b1, 0);
        for (int i = 1; i < 8; i++) addVec(1'b0, 16'h0, 16'h8000, 16'h8000, 1'b1, 0);

        foreach (vecs[i]) begin
            if (vecs[i].load) loadAll(vecs[i].coef);
            pushSample(vecs[i].sample, vecs[i].hold, 1'b0, 1'b0, vecs[i].expected,
                       vecs[i].chk, $sformatf("vec%0d", i));
        end

        // Coefficient gating: a write during MAC is dropped.
        loadAll(16'h0000);
        writeCoef(0, 16'h4000);
        for (int i = 0; i < TAPS; i++) pushSample(16'h0000, 0, 1'b0, 1'b0, 16'h0, 1'b0, "flush");
        pushSample(16'h7FFF, 0, 1'b1, 1'b0, 16'h1FFF, 1'b1, "macWrite");
        // The same write alongside an accepted sample lands first.
        pushSample(16'h7FFF, 0, 1'b0, 1'b1, 16'h07FF, 1'b1, "idleWrite");

        // Reset mid-MAC discards the partial result.
        xInValid = 1'b1;
        xInData  = 16'h7FFF;
        tick();
        xInValid = 1'b0;
        tick();
        tick();
        @(posedge xClk);
        #1;
        xRst_n = 1'b0;
        modelClear();
        tick();
        check("midRst_mulAB", {xMulA, xMulB}, 32'd0);
        xRst_n = 1'b1;
        sawValid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (xOutValid) sawValid = 1'b1;
        end
        check("midRst_noValid", 32'(sawValid), 32'd0);
        check("midRst_idle", {30'd0, xInReady, xBusy}, 32'b10);
        check("midRst_outData", 32'(xOutData), 32'd0);
        writeCoef(0, 16'h4000);
        pushSample(16'h7FFF, 0, 1'b0, 1'b0, 16'h1FFF, 1'b1, "postRst");

        // Randomized coefficients and samples against the model.
        for (int i = 0; i < 40; i++) begin
            if ((i % 10) == 0) begin
                for (int k = 0; k < TAPS; k++) writeCoef(k, 16'($urandom));
            end else if ($urandom_range(0, 3) == 0) begin
                writeCoef(int'($urandom_range(0, TAPS - 1)), 16'($urandom));
            end
            rs = 16'($urandom);
            if ($urandom_range(0, 4) == 0) rs = ($urandom_range(0, 1) == 1) ? 16'h7FFF : 16'h8000;
            pushSample(rs, int'($urandom_range(0, 2)), 1'b0, 1'b0, 16'h0, 1'b0,
                       $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
